// File: rtl/sram_ctrl_seq.sv
// Self-sequencing asynchronous SRAM controller: IDLE -> SETUP -> ACCESS -> HOLD.
// Define SRAM_B2B_EN to accept the next request during HOLD and skip IDLE.
module sram_ctrl_seq #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   inout  wire  [DATA_W-1:0] ram_data
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state;
   state_t            state_next;
   logic [3:0]        wait_cnt;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic              bus_drive;
   logic              accept;
   logic              lat_we_d;
   logic              ce_n_d;
   logic              oe_n_d;
   logic              we_n_d;
   logic              drive_d;
   logic              rsp_valid_d;

`ifdef SRAM_B2B_EN
   assign req_ready = (state == IDLE) || (state == HOLD);
`else
   assign req_ready = (state == IDLE);
`endif

   assign accept   = req_valid && req_ready;
   assign lat_we_d = accept ? req_we : lat_we;
   assign ram_data = bus_drive ? lat_wdata : 'z;

   // Without SRAM_B2B_EN, accept is never high in HOLD, so HOLD always returns to IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (wait_cnt == 4'd0) state_next = HOLD;
         HOLD:    state_next = accept ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pin values are decoded from the state being entered so every pin comes straight from a flop.
   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      ce_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      drive_d     = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_next)
         SETUP: drive_d = lat_we_d;
         ACCESS: begin
            ce_n_d  = 1'b0;
            oe_n_d  = lat_we_d;
            we_n_d  = ~lat_we_d;
            drive_d = lat_we_d;
         end
         HOLD: begin
            drive_d     = lat_we_d;
            rsp_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         ram_addr  <= '0;
         ram_ce_n  <= 1'b1;
         ram_oe_n  <= 1'b1;
         ram_we_n  <= 1'b1;
         bus_drive <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            ram_addr  <= req_addr;
         end
         if (state == SETUP) begin
            wait_cnt <= WAIT_INIT;
         end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (state == ACCESS && wait_cnt == 4'd0 && !lat_we) begin
            rsp_rdata <= ram_data;
         end
         ram_ce_n  <= ce_n_d;
         ram_oe_n  <= oe_n_d;
         ram_we_n  <= we_n_d;
         bus_drive <= drive_d;
         rsp_valid <= rsp_valid_d;
      end
   end

endmodule

// File: tb/tb_sram_ctrl_seq.sv
// Bench for sram_ctrl_seq: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0,
// sharing a behavioural async SRAM; expected read data flows through a scoreboard queue.
module tb_sram_ctrl_seq;

   localparam int DW = 16;
   localparam int AW = 18;
   localparam int WA = 1;
   localparam int WB = 0;
`ifdef SRAM_B2B_EN
   localparam int RSP_GAP = WA + 3;
   localparam int HS_LAG  = 0;
   localparam bit B2B     = 1'b1;
`else
   localparam int RSP_GAP = WA + 4;
   localparam int HS_LAG  = 1;
   localparam bit B2B     = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          a_req_valid, a_req_we;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_wdata;
   wire           a_req_ready, a_rsp_valid, a_ce_n, a_oe_n, a_we_n;
   wire  [DW-1:0] a_rsp_rdata;
   wire  [AW-1:0] a_ram_addr;
   wire  [DW-1:0] a_ram_data;

   logic          b_req_valid, b_req_we;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata;
   wire           b_req_ready, b_rsp_valid, b_ce_n, b_oe_n, b_we_n;
   wire  [DW-1:0] b_rsp_rdata;
   wire  [AW-1:0] b_ram_addr;
   wire  [DW-1:0] b_ram_data;

   sram_ctrl_seq #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WA)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
      .ram_addr(a_ram_addr), .ram_ce_n(a_ce_n), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n),
      .ram_data(a_ram_data)
   );

   sram_ctrl_seq #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WB)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .ram_addr(b_ram_addr), .ram_ce_n(b_ce_n), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n),
      .ram_data(b_ram_data)
   );

   // Behavioural async SRAM shared by both controllers.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign a_ram_data = (!a_ce_n && !a_oe_n) ? mem[a_ram_addr] : 'z;
   assign b_ram_data = (!b_ce_n && !b_oe_n) ? mem[b_ram_addr] : 'z;
   always @(posedge clk) begin
      if (rst) mem[18'h00123] <= 16'hA5C3;
      if (!a_ce_n && !a_we_n) mem[a_ram_addr] <= a_ram_data;
      if (!b_ce_n && !b_we_n) mem[b_ram_addr] <= b_ram_data;
   end

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("a_oe_we_exclusive", 32'(a_oe_n | a_we_n), 1);
      check("b_oe_we_exclusive", 32'(b_oe_n | b_we_n), 1);
   endtask

   task automatic sb_check(input string tag, input logic [DW-1:0] obs);
      if (sb_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
      else check(tag, obs, sb_q.pop_front());
   endtask

   task automatic wait_ready_a();
      int n = 0;
      while (!a_req_ready && n < 50) begin
         tick();
         n++;
      end
      check("a_ready_timeout", a_req_ready, 1);
   endtask

   // One request on instance a, checked cycle by cycle against the phase sequence.
   task automatic a_access(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
      int got = 0;
      int ce_low = 0;
      int we_low = 0;
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      a_req_valid = 1'b1;
      wait_ready_a();
      @(posedge clk);
      #1 a_req_valid = 1'b0;
      sb_q.push_back(we ? last_rdata : exp_rd);
      if (!we) last_rdata = exp_rd;
      for (int k = 1; k <= 20 && got == 0; k++) begin
         tick();
         if (!a_ce_n) ce_low++;
         if (!a_we_n) we_low++;
         if (k == 1) begin
            check("setup_addr", a_ram_addr, addr);
            check("setup_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
            check("setup_drive", u_a.bus_drive, we);
            if (we) check("setup_bus", a_ram_data, wdata);
         end else if (k <= WA + 2) begin
            check("access_strobes", {a_ce_n, a_oe_n, a_we_n}, {1'b0, we, ~we});
            check("access_drive", u_a.bus_drive, we);
            check("access_addr", a_ram_addr, addr);
            if (we) check("access_bus", a_ram_data, wdata);
         end
         if (a_rsp_valid) begin
            got = k;
            check("rsp_latency", k, WA + 3);
            check("hold_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
            check("hold_addr", a_ram_addr, addr);
            check("hold_drive", u_a.bus_drive, we);
            sb_check("rsp_rdata", a_rsp_rdata);
         end
      end
      check("rsp_seen", 32'(got != 0), 1);
      check("ce_low_cycles", ce_low, WA + 1);
      check("we_low_cycles", we_low, we ? WA + 1 : 0);
      tick();
      check("idle_rsp_off", a_rsp_valid, 0);
      check("idle_drive", u_a.bus_drive, 0);
      check("idle_ready", a_req_ready, 1);
   endtask

   initial begin
      int rsp1, rsp2, hs, got, ce_low;
      rst = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      last_rdata = '0;

      // Reset state
      tick();
      tick();
      check("rst_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
      check("rst_addr", a_ram_addr, 0);
      check("rst_rsp_valid", a_rsp_valid, 0);
      check("rst_rsp_rdata", a_rsp_rdata, 0);
      check("rst_drive", u_a.bus_drive, 0);
      check("rst_b_strobes", {b_ce_n, b_oe_n, b_we_n}, 3'b111);
      rst = 1'b0;
      tick();
      check("rst_ready", a_req_ready, 1);

      // Read, write to the top address, read-back
      a_access(1'b0, 18'h00123, 16'h0000, 16'hA5C3);
      a_access(1'b1, 18'h3FFFF, 16'h1234, 16'h0000);
      a_access(1'b0, 18'h3FFFF, 16'h0000, 16'h1234);

      // Reset during the second ACCESS cycle of a write
      a_req_we = 1'b1; a_req_addr = 18'h00500; a_req_wdata = 16'hBEEF; a_req_valid = 1'b1;
      wait_ready_a();
      @(posedge clk);
      #1 a_req_valid = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_we_n", a_we_n, 0);
      rst = 1'b1;
      tick();
      check("abort_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
      check("abort_drive", u_a.bus_drive, 0);
      check("abort_rsp_valid", a_rsp_valid, 0);
      rst = 1'b0;
      last_rdata = '0;
      tick();
      check("abort_no_late_rsp", a_rsp_valid, 0);
      check("abort_ready", a_req_ready, 1);

      // Read followed by a write held pending on req_valid
      a_req_we = 1'b0; a_req_addr = 18'h00123; a_req_valid = 1'b1;
      wait_ready_a();
      @(posedge clk);
      #1;
      sb_q.push_back(16'hA5C3);
      sb_q.push_back(16'hA5C3);
      last_rdata = 16'hA5C3;
      a_req_we = 1'b1; a_req_addr = 18'h00200; a_req_wdata = 16'h5A5A;
      rsp1 = 0; rsp2 = 0; hs = 0;
      for (int k = 1; k <= 30 && rsp2 == 0; k++) begin
         tick();
         if (k <= WA + 2) check("busy_ready", a_req_ready, 0);
         if (k == WA + 3) check("hold_ready", a_req_ready, B2B);
         if (hs != 0 && k == hs + 1) begin
            check("q_setup_addr", a_ram_addr, 18'h00200);
            check("q_setup_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
            check("q_setup_drive", u_a.bus_drive, 1);
            check("q_setup_bus", a_ram_data, 16'h5A5A);
         end
         if (a_rsp_valid) begin
            if (rsp1 == 0) rsp1 = k;
            else rsp2 = k;
            sb_check("q_rsp_rdata", a_rsp_rdata);
         end
         if (hs == 0 && a_req_ready && a_req_valid) begin
            hs = k;
            @(posedge clk);
            #1 a_req_valid = 1'b0;
         end
      end
      check("q_first_rsp", rsp1, WA + 3);
      check("q_handshake_cycle", hs, rsp1 + HS_LAG);
      check("q_rsp_spacing", rsp2 - rsp1, RSP_GAP);
      tick();
      a_access(1'b0, 18'h00200, 16'h0000, 16'h5A5A);

      // WAIT_CYCLES=0 instance
      b_req_we = 1'b0; b_req_addr = 18'h00123; b_req_valid = 1'b1;
      check("b_ready", b_req_ready, 1);
      @(posedge clk);
      #1 b_req_valid = 1'b0;
      got = 0; ce_low = 0;
      for (int k = 1; k <= 10 && got == 0; k++) begin
         tick();
         if (!b_ce_n) ce_low++;
         if (b_rsp_valid) got = k;
      end
      check("b_rsp_latency", got, WB + 3);
      check("b_rsp_rdata", b_rsp_rdata, 16'hA5C3);
      check("b_ce_low_cycles", ce_low, WB + 1);
      check("b_drive", u_b.bus_drive, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_ctrl_seq.md
Name: sram_ctrl_seq

Overview:
- Self-sequencing asynchronous SRAM controller for the THCO-MIPS memory path.
- Accepts single read/write requests over a valid/ready handshake and generates the SRAM address and active-low strobes from its own state machine; callers no longer supply a phase input.
- Drives the bidirectional data bus and returns read data with a one-cycle response pulse.
- Width, address size and access wait states are parametrised for the base and extended RAM chips.

Parameters:
- DATA_W, 16, SRAM and request data width.
- ADDR_W, 18, SRAM address width.
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first; legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  0 = read, 1 = write.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; access complete.
- rsp_rdata  out  DATA_W  read data, held until the next read completes.
- ram_addr  out  ADDR_W  SRAM address.
- ram_ce_n  out  1  chip enable, active-low.
- ram_oe_n  out  1  output enable, active-low.
- ram_we_n  out  1  write enable, active-low.
- ram_data  inout  DATA_W  SRAM data bus; high-Z unless a write is in progress.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, wait counter 0, ram_ce_n/oe_n/we_n=1, ram_addr=0, ram_data high-Z, rsp_valid=0, rsp_rdata=0, latched we/wdata=0.
- Reset takes effect at the next edge from any state. An in-flight access is abandoned with no rsp_valid.
- All pin outputs are registered; no combinational path from req_* to ram_*.
- req_ready=1 only in IDLE, unless SRAM_B2B_EN is defined. It is combinational from state.
- State IDLE:
  - Strobes inactive; bus high-Z.
  - On handshake, latch addr, we and wdata, then go to SETUP.
- State SETUP (1 cycle):
  - ram_addr = latched addr; strobes inactive.
  - For a write, ram_data is driven with wdata.
  - Go to ACCESS and load the counter with WAIT_CYCLES.
- State ACCESS (WAIT_CYCLES+1 cycles):
  - ram_ce_n=0.
  - Read: ram_oe_n=0, ram_we_n=1, bus high-Z.
  - Write: ram_oe_n=1, ram_we_n=0, bus driven.
  - The counter decrements each cycle; at 0, go to HOLD.
  - Read: ram_data is sampled into rsp_rdata at the edge leaving ACCESS.
- State HOLD (1 cycle):
  - All strobes are 1; address is held.
  - Write data is still driven (hold time); the bus is released at exit.
  - rsp_valid=1 for this cycle only. Go to IDLE.
- Latency: a handshake at edge T gives rsp_valid high in cycle T+WAIT_CYCLES+3.
  - WAIT_CYCLES=1: rsp_valid is high in the 4th cycle after acceptance.
  - Throughput is one access per WAIT_CYCLES+4 cycles.
- Request inputs are ignored while req_ready=0. The requester must hold req_valid and its payload stable until accepted.
- A write leaves rsp_rdata unchanged.
- The counter never wraps: it is loaded only in SETUP and saturates at 0.
- ram_we_n and ram_oe_n are never 0 simultaneously; ram_we_n is never 0 while ram_addr changes.

Optional Feature:
- Macro: SRAM_B2B_EN.
- Defined:
  - req_ready is also 1 in HOLD.
  - A handshake in HOLD latches the new request and goes directly to SETUP, skipping IDLE.
  - HOLD still deasserts all strobes and still pulses rsp_valid for the finishing access.
  - Throughput is one access per WAIT_CYCLES+3 cycles.
  - A write following a read in this way drives the bus from SETUP onward, as in the normal case.
- Undefined:
  - HOLD always returns to IDLE.
  - req_ready is 0 in HOLD.

Test Plan:
- Read, WAIT_CYCLES=1, SRAM model holds 0xA5C3 at 0x00123 → SETUP: ram_addr=0x00123. ACCESS: ce_n=0 and oe_n=0 for 2 cycles. rsp_valid in cycle T+4 with rsp_rdata=0xA5C3. Bus high-Z throughout.
- Write 0x1234 to 0x3FFFF, WAIT_CYCLES=1 → we_n=0 for exactly 2 cycles. Bus driven 0x1234 from SETUP through HOLD. A read-back returns 0x1234. rsp_rdata is unchanged by the write.
- WAIT_CYCLES=0 read → ACCESS lasts 1 cycle; rsp_valid in cycle T+3.
- rst asserted during the 2nd ACCESS cycle of a write → next edge: all strobes 1, bus high-Z, state IDLE, no rsp_valid. req_ready=1 once rst is deasserted.
- req_valid held through a busy period, with a second request queued behind an access → req_ready=0 until IDLE. The second request starts exactly one cycle after the first rsp_valid, and its payload is captured unchanged.
- Two back-to-back reads with SRAM_B2B_EN defined → rsp_valid pulses 4 cycles apart (WAIT_CYCLES=1). Without the macro → 5 cycles apart.
